// File: rtl/shift_reg_seq_pkg.sv
// Shared types and mode encodings for the shift register and its sequencer.
// Latency: none; declarations only.
// Backpressure: not applicable.
package shift_reg_pkg;

   // Encodings as seen on the Mode port; anything above ROL is a no-op.
   localparam logic [2:0] MODE_LSR = 3'b000;
   localparam logic [2:0] MODE_LSL = 3'b001;
   localparam logic [2:0] MODE_ASR = 3'b010;
   localparam logic [2:0] MODE_ROR = 3'b011;
   localparam logic [2:0] MODE_ROL = 3'b100;

   typedef enum logic [2:0] {
      LSR = MODE_LSR,
      LSL = MODE_LSL,
      ASR = MODE_ASR,
      ROR = MODE_ROR,
      ROL = MODE_ROL
   } shift_mode_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seq_state_t;

endpackage

// File: rtl/shift_step.sv
// One-step shift next-value and expelled-bit function for a WIDTH-bit register.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to commit the result.
module shift_step
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q_i,
   input  logic [2:0]       mode_i,
   input  logic             shift_in_i,
   output logic [WIDTH-1:0] q_o,
   output logic             shift_out_o
);

   // Next value and the bit that this shift would push out of the register.
   always_comb begin
      q_o         = q_i;
      shift_out_o = 1'b0;
      case (mode_i)
         MODE_LSR: begin
            q_o         = {shift_in_i, q_i[WIDTH-1:1]};
            shift_out_o = q_i[0];
         end
         MODE_LSL: begin
            q_o         = {q_i[WIDTH-2:0], shift_in_i};
            shift_out_o = q_i[WIDTH-1];
         end
         MODE_ASR: begin
            q_o         = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            shift_out_o = q_i[0];
         end
         MODE_ROR: begin
            q_o         = {q_i[0], q_i[WIDTH-1:1]};
            shift_out_o = q_i[0];
         end
         MODE_ROL: begin
            q_o         = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            shift_out_o = q_i[WIDTH-1];
         end
         default: begin
            q_o         = q_i;
            shift_out_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/shift_reg_seq.sv
// Load/shift register with five shift modes and a counted-shift sequencer (Start/Busy/Done).
// Latency: load and manual shift 1 cycle; Start with N>0 shifts on the next N edges, Done with the final value.
// Backpressure: none; Load aborts a running sequence, Start/Shift_En are ignored while Busy.
module shift_reg_seq
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   Load,
   input  logic [WIDTH-1:0]       D,
   input  logic                   Shift_En,
   input  logic                   Shift_In,
   input  logic [2:0]             Mode,
   input  logic                   Start,
   input  logic [$clog2(WIDTH):0] Count,
   output logic                   Busy,
   output logic                   Done,
   output logic                   Shift_Out,
   output logic [WIDTH-1:0]       Data_Out
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   seq_state_t        state_q, state_d;
   logic [WIDTH-1:0]  data_q,  data_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [2:0]        mode_q,  mode_d;
   logic              done_q,  done_d;

   logic [2:0]        act_mode;
   logic [WIDTH-1:0]  step_q;
   logic              step_out;

   // A running sequence uses the mode captured at Start, not the live input.
   assign act_mode = (state_q == RUN) ? mode_q : Mode;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .q_i         (data_q),
      .mode_i      (act_mode),
      .shift_in_i  (Shift_In),
      .q_o         (step_q),
      .shift_out_o (step_out)
   );

   // State register: synchronous reset clears everything, including a sequence in flight.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         mode_q  <= MODE_LSR;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

   // Next state: Load > sequenced step > Start > manual shift; Done only pulses when set.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      if (Load) begin
         data_d  = D;
         state_d = IDLE;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         data_d = step_q;
         cnt_d  = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end else if (Start) begin
         if (Count == '0) begin
            done_d = 1'b1;
         end else begin
            mode_d  = Mode;
            cnt_d   = Count;
            state_d = RUN;
         end
      end else if (Shift_En) begin
         data_d = step_q;
      end
   end

   // Outputs decoded straight from registers, except Shift_Out which follows the active mode.
   always_comb begin
      Busy      = (state_q == RUN);
      Done      = done_q;
      Data_Out  = data_q;
      Shift_Out = step_out;
   end

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed table of per-cycle vectors plus counted-sequence checks for shift_reg_seq.
// Latency: each vector is one clock; outputs sampled on the falling edge.
// Backpressure: none.
module tb_shift_reg_seq;

   logic       Clk = 1'b0;
   logic       Reset, Load, Shift_En, Shift_In, Start;
   logic [7:0] D;
   logic [2:0] Mode;
   logic [3:0] Count;
   logic       Busy, Done, Shift_Out;
   logic [7:0] Data_Out;

   int n_vec = 0;
   int n_err = 0;

   always #5 Clk = ~Clk;

   shift_reg_seq #(.WIDTH(8)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Load      (Load),
      .D         (D),
      .Shift_En  (Shift_En),
      .Shift_In  (Shift_In),
      .Mode      (Mode),
      .Start     (Start),
      .Count     (Count),
      .Busy      (Busy),
      .Done      (Done),
      .Shift_Out (Shift_Out),
      .Data_Out  (Data_Out)
   );

   typedef struct {
      logic       rst;
      logic       ld;
      logic [7:0] d;
      logic       sen;
      logic       sin;
      logic [2:0] mode;
      logic       st;
      logic [3:0] cnt;
      logic [7:0] eq;
      logic       eb;
      logic       ed;
      logic       eso;
   } vec_t;

   vec_t tbl[$];

   localparam logic [2:0] M_LSR = 3'd0, M_LSL = 3'd1, M_ASR = 3'd2,
                          M_ROR = 3'd3, M_ROL = 3'd4, M_NOP = 3'd5;

   function automatic vec_t v(input logic rst, input logic ld, input logic [7:0] d,
                              input logic sen, input logic sin, input logic [2:0] mode,
                              input logic st, input logic [3:0] cnt,
                              input logic [7:0] eq, input logic eb, input logic ed,
                              input logic eso);
      vec_t r;
      r.rst = rst; r.ld = ld; r.d = d; r.sen = sen; r.sin = sin; r.mode = mode;
      r.st = st; r.cnt = cnt; r.eq = eq; r.eb = eb; r.ed = ed; r.eso = eso;
      return r;
   endfunction

   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic drive_idle();
      Reset = 1'b0; Load = 1'b0; D = 8'h00; Shift_En = 1'b0;
      Shift_In = 1'b0; Start = 1'b0; Count = 4'd0;
   endtask

   // Load, start a counted sequence and watch Busy/Done with a bounded wait.
   task automatic run_counted(input string name, input logic [2:0] m, input logic [3:0] n,
                              input logic [7:0] d0, input logic [7:0] exp);
      int   busy_cyc;
      bit   got;
      logic [7:0] qd;
      drive_idle();
      Load = 1'b1; D = d0; Mode = m;
      tick();
      Load = 1'b0; Start = 1'b1; Count = n;
      tick();
      Start = 1'b0; Count = 4'd0;
      busy_cyc = 0; got = 1'b0; qd = 8'h00;
      for (int i = 0; i < 64 && !got; i++) begin
         if (Busy) busy_cyc++;
         if (Done) begin
            got = 1'b1;
            qd  = Data_Out;
         end else begin
            tick();
         end
      end
      n_vec++;
      if (!got || busy_cyc != int'(n) || qd !== exp) begin
         n_err++;
         $display("FAIL %s: done_seen=%0d busy_cycles=%0d data=%02h, required done_seen=1 busy_cycles=%0d data=%02h",
                  name, got, busy_cyc, qd, n, exp);
      end
      tick();
      n_vec++;
      if (Done !== 1'b0 || Busy !== 1'b0 || Data_Out !== exp) begin
         n_err++;
         $display("FAIL %s_after: done=%b busy=%b data=%02h, required done=0 busy=0 data=%02h",
                  name, Done, Busy, Data_Out, exp);
      end
   endtask

   initial begin
      // Reset, load, manual shifts in every mode.
      tbl.push_back(v(1,0,8'h00,0,0,M_LSR,0,0, 8'h00,0,0,0));
      tbl.push_back(v(0,1,8'hA5,0,0,M_LSR,0,0, 8'hA5,0,0,1));
      tbl.push_back(v(0,0,8'h00,1,1,M_LSR,0,0, 8'hD2,0,0,0));
      tbl.push_back(v(0,0,8'h00,0,0,M_LSL,0,0, 8'hD2,0,0,1));
      tbl.push_back(v(0,0,8'h00,1,0,M_NOP,0,0, 8'hD2,0,0,0));
      tbl.push_back(v(0,0,8'h00,1,0,M_ROR,0,0, 8'h69,0,0,1));
      tbl.push_back(v(0,0,8'h00,1,0,M_ROL,0,0, 8'hD2,0,0,1));
      tbl.push_back(v(0,0,8'h00,1,0,M_ASR,0,0, 8'hE9,0,0,1));
      tbl.push_back(v(0,0,8'h00,1,0,M_LSL,0,0, 8'hD2,0,0,1));
      // ASR x3 on 0x81; Mode/Start/Shift_En changes while running are ignored.
      tbl.push_back(v(0,1,8'h81,0,0,M_ASR,0,0, 8'h81,0,0,1));
      tbl.push_back(v(0,0,8'h00,0,0,M_ASR,1,3, 8'h81,1,0,1));
      tbl.push_back(v(0,0,8'h00,0,0,M_ROL,0,0, 8'hC0,1,0,0));
      tbl.push_back(v(0,0,8'h00,1,0,M_ROL,1,2, 8'hE0,1,0,0));
      tbl.push_back(v(0,0,8'h00,0,0,M_ASR,0,0, 8'hF0,0,1,0));
      tbl.push_back(v(0,0,8'h00,0,0,M_ASR,0,0, 8'hF0,0,0,0));
      // LSL x4 with Shift_In=1, Shift_En pulsed mid-run.
      tbl.push_back(v(0,1,8'h00,0,1,M_LSL,0,0, 8'h00,0,0,0));
      tbl.push_back(v(0,0,8'h00,0,1,M_LSL,1,4, 8'h00,1,0,0));
      tbl.push_back(v(0,0,8'h00,0,1,M_LSL,0,0, 8'h01,1,0,0));
      tbl.push_back(v(0,0,8'h00,1,1,M_LSL,0,0, 8'h03,1,0,0));
      tbl.push_back(v(0,0,8'h00,1,1,M_LSL,0,0, 8'h07,1,0,0));
      tbl.push_back(v(0,0,8'h00,0,1,M_LSL,0,0, 8'h0F,0,1,0));
      tbl.push_back(v(0,0,8'h00,0,0,M_LSL,0,0, 8'h0F,0,0,0));
      // ROL x5 aborted by Load on the second busy cycle.
      tbl.push_back(v(0,1,8'h01,0,0,M_ROL,0,0, 8'h01,0,0,0));
      tbl.push_back(v(0,0,8'h00,0,0,M_ROL,1,5, 8'h01,1,0,0));
      tbl.push_back(v(0,0,8'h00,0,0,M_ROL,0,0, 8'h02,1,0,0));
      tbl.push_back(v(0,1,8'h55,0,0,M_ROL,0,0, 8'h55,0,0,0));
      tbl.push_back(v(0,0,8'h00,0,0,M_ROL,0,0, 8'h55,0,0,0));
      tbl.push_back(v(0,0,8'h00,0,0,M_ROL,0,0, 8'h55,0,0,0));
      // Count=0: immediate Done, no data change, no Busy.
      tbl.push_back(v(0,0,8'h00,0,0,M_LSR,1,0, 8'h55,0,1,1));
      tbl.push_back(v(0,0,8'h00,0,0,M_LSR,0,0, 8'h55,0,0,1));
      // ROR x5 killed by Reset on the third busy cycle.
      tbl.push_back(v(0,0,8'h00,0,0,M_ROR,1,5, 8'h55,1,0,1));
      tbl.push_back(v(0,0,8'h00,0,0,M_ROR,0,0, 8'hAA,1,0,0));
      tbl.push_back(v(0,0,8'h00,0,0,M_ROR,0,0, 8'h55,1,0,1));
      tbl.push_back(v(1,0,8'h00,0,0,M_ROR,0,0, 8'h00,0,0,0));
      tbl.push_back(v(0,0,8'h00,0,0,M_ROR,0,0, 8'h00,0,0,0));
      tbl.push_back(v(0,0,8'h00,0,0,M_ROR,0,0, 8'h00,0,0,0));

      drive_idle();
      Reset = 1'b1; Mode = M_LSR;
      @(negedge Clk);

      foreach (tbl[i]) begin
         Reset = tbl[i].rst; Load = tbl[i].ld; D = tbl[i].d; Shift_En = tbl[i].sen;
         Shift_In = tbl[i].sin; Mode = tbl[i].mode; Start = tbl[i].st; Count = tbl[i].cnt;
         tick();
         n_vec++;
         if (Data_Out !== tbl[i].eq || Busy !== tbl[i].eb || Done !== tbl[i].ed ||
             Shift_Out !== tbl[i].eso) begin
            n_err++;
            $display("FAIL vec%0d: data=%02h busy=%b done=%b so=%b, required data=%02h busy=%b done=%b so=%b",
                     i, Data_Out, Busy, Done, Shift_Out,
                     tbl[i].eq, tbl[i].eb, tbl[i].ed, tbl[i].eso);
         end
      end

      run_counted("rol8",  M_ROL, 4'd8, 8'h3C, 8'h3C);
      run_counted("rol9",  M_ROL, 4'd9, 8'h81, 8'h03);
      run_counted("lsr9",  M_LSR, 4'd9, 8'hFF, 8'h00);
      run_counted("ror1",  M_ROR, 4'd1, 8'h01, 8'h80);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/shift_reg_seq.md
Name: shift_reg_seq

Overview:
- Parametrised successor to the team's fixed 8-bit load/shift register.
- Generalised to WIDTH bits with five shift modes: logical right/left, arithmetic right, rotate right/left.
- Adds a counted-shift sequencer: a single Start command performs N shifts autonomously, with Busy/Done handshake.
- Serves as the operand/accumulator register for shift-add multiply, serial I/O and barrel-free shift datapaths.

Parameters:
- WIDTH, 8, data register width in bits (>= 2).
- CNT_W, $clog2(WIDTH)+1, width of the Count port (derived localparam; do not override).

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Load  in  1  parallel load of D.
- D  in  WIDTH  parallel load data.
- Shift_En  in  1  single manual shift in Mode (IDLE only).
- Shift_In  in  1  serial input bit for LSR/LSL.
- Mode  in  3  shift mode: 000 LSR, 001 LSL, 010 ASR, 011 ROR, 100 ROL, others no-op.
- Start  in  1  begin counted shift sequence.
- Count  in  CNT_W  number of shifts for Start.
- Busy  out  1  sequence in progress.
- Done  out  1  one-cycle pulse: sequence complete.
- Shift_Out  out  1  bit that the next shift in the active mode expels.
- Data_Out  out  WIDTH  register contents.

Behaviour:
- Reset: Data_Out=0, state=IDLE, Busy=0, Done=0, internal count=0, latched mode=LSR. Reset overrides every other input, including mid-sequence.
- One-step shift:
  - LSR: {Shift_In, Q[W-1:1]}
  - LSL: {Q[W-2:0], Shift_In}
  - ASR: {Q[W-1], Q[W-1:1]}
  - ROR: {Q[0], Q[W-1:1]}
  - ROL: {Q[W-2:0], Q[W-1]}
  - Modes 101-111: Q unchanged.
- Shift_Out (combinational):
  - Q[0] for LSR/ASR/ROR.
  - Q[W-1] for LSL/ROL.
  - 0 for no-op modes.
  - Active mode is the Mode input in IDLE and the latched mode in RUN.
- Priority per edge: Reset > Load > RUN step > Start > Shift_En.
- Load: Data_Out<=D next edge. In RUN, Load aborts the sequence: state->IDLE, Busy falls, no Done pulse.
- Shift_En (IDLE, no Load, no Start): one shift in Mode; latency 1 cycle.
- FSM states:
  - IDLE:
    - Start with Count=N>0 latches Mode and N, then goes to RUN; no shift on the Start edge.
    - Start with Count=0 stays in IDLE and sets Done=1 for the next cycle; Data_Out is unchanged.
  - RUN:
    - Each edge performs one shift in the latched mode and decrements the count.
    - Shift_In is sampled live every cycle.
    - On the edge performing shift N: state->IDLE, Done<=1.
- Timing for Start at edge k with N>0:
  - Shifts occur at edges k+1..k+N.
  - Busy=1 for exactly N cycles.
  - Done=1 for exactly one cycle, in which Data_Out first shows the final value.
- Busy = (state==RUN), decoded directly from the state register.
- Start, Shift_En and Mode changes during RUN are ignored.
- Count > WIDTH is legal: rotates wrap; logical shifts fill fully.
- Done is a registered output. It is cleared on every edge unless it is being set.

Decomposition:
- Package shift_reg_pkg:
  - shift_mode_t enum (LSR, LSL, ASR, ROR, ROL).
  - seq_state_t enum (IDLE, RUN).
  - Mode encoding constants.
- Sub-module shift_step: combinational one-step next-value and Shift_Out function, parametrised by WIDTH.
  - Instantiated once.
  - Shared by the manual and sequenced paths.

Test Plan:
- WIDTH=8. Reset, Load D=0xA5 -> Data_Out=0xA5, Shift_Out=1. Shift_En, LSR, Shift_In=1 -> 0xD2, Shift_Out=0.
- Load 0x81. Start Mode=ASR Count=3 -> Busy high 3 cycles, intermediate values 0xC0, 0xE0. Done one cycle with Data_Out=0xF0.
- Load 0x3C, ROL Count=8 -> 0x3C with Done after 8 Busy cycles. Load 0x81, ROL Count=9 -> 0x03.
- Load 0x00, LSL Count=4 with Shift_In=1 -> 0x0F. Shift_En pulsed during RUN -> no extra shift.
- Load 0x01, ROL Count=5. Load D=0x55 on the 2nd Busy cycle -> Data_Out=0x55 next cycle, Busy=0, Done never asserts.
- Start Count=0 -> Done next cycle, Busy stays 0, Data_Out unchanged. Reset on the 3rd Busy cycle -> Data_Out=0, Busy=0, Done=0.
